// File: rtl/sonar_rx_pkg.sv
// Shared definitions for the sonar serial receiver: bit-level state codes,
// frame characters and the per-position character check.
package sonar_rx_pkg;

  typedef enum logic [3:0] {
    ST_REPOUSO  = 4'd0,
    ST_INICIO   = 4'd1,
    ST_DADOS    = 4'd2,
    ST_PARIDADE = 4'd3,
    ST_PARADA1  = 4'd4,
    ST_PARADA2  = 4'd5,
    ST_ENTREGA  = 4'd6
  } rx_state_t;

  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_HASH  = 8'h23;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
  endfunction

  // Frame layout is A2 A1 A0 ',' D2 D1 D0 '#'.
  function automatic logic char_ok(input logic [2:0] pos, input logic [7:0] c);
    case (pos)
      3'd3:    return c == ASCII_COMMA;
      3'd7:    return c == ASCII_HASH;
      default: return is_digit(c);
    endcase
  endfunction

endpackage

// File: rtl/sonar_rx_if.sv
// Serial input and decoded outputs of the sonar receiver.
interface sonar_rx_if;
  logic        rx;
  logic [11:0] angulo;
  logic [11:0] distancia;
  logic        pronto;
  logic        erro_serial;
  logic        erro_formato;
  logic [3:0]  db_estado;

  // The receiver drives the decoded values.
  modport master (
    input  rx,
    output angulo, distancia, pronto, erro_serial, erro_formato, db_estado
  );

  // The line source / consumer of the decoded values.
  modport slave (
    output rx,
    input  angulo, distancia, pronto, erro_serial, erro_formato, db_estado
  );
endinterface

// File: rtl/sonar_rx_serial.sv
// Bit-level 7E2 receiver: synchronizes rx, samples mid-bit and delivers one
// character per frame in a single entrega cycle, flagged good or bad.
module sonar_rx_serial
  import sonar_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_error,
  output logic [3:0] db_estado
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic            rx_meta, rx_sync, rx_prev;
  rx_state_t       state, state_next;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [6:0]      data;
  logic            par_bit, stop1, stop2;
  logic            fall, tick, frame_err;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value; blocking here would collapse the chain.
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall = rx_prev & ~rx_sync;
  assign tick = (state == ST_INICIO) ? (cnt == HALF_LAST) : (cnt == FULL_LAST);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_REPOUSO;
    else       state <= state_next;
  end

  // Next-state logic: one sample per tick, half a bit into the start bit.
  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      ST_REPOUSO:  if (fall) state_next = ST_INICIO;
      ST_INICIO:   if (tick) state_next = rx_sync ? ST_REPOUSO : ST_DADOS;
      ST_DADOS:    if (tick && bit_idx == 3'd6) state_next = ST_PARIDADE;
      ST_PARIDADE: if (tick) state_next = ST_PARADA1;
      ST_PARADA1:  if (tick) state_next = ST_PARADA2;
      ST_PARADA2:  if (tick) state_next = ST_ENTREGA;
      ST_ENTREGA:  state_next = ST_REPOUSO;
      default:     state_next = ST_REPOUSO;
    endcase
  end

  // Bit timer and sampled bits of the current character.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: datapath registers are reset too, so a reset mid-character leaves nothing stale.
      cnt     <= '0;
      bit_idx <= '0;
      data    <= '0;
      par_bit <= 1'b0;
      stop1   <= 1'b0;
      stop2   <= 1'b0;
    end else begin
      cnt <= (state == ST_REPOUSO || tick) ? '0 : cnt + 1'b1;
      if (state == ST_REPOUSO) bit_idx <= '0;
      if (tick) begin
        case (state)
          ST_DADOS: begin
            data    <= {rx_sync, data[6:1]};
            bit_idx <= bit_idx + 1'b1;
          end
          ST_PARIDADE: par_bit <= rx_sync;
          ST_PARADA1:  stop1   <= rx_sync;
          ST_PARADA2:  stop2   <= rx_sync;
          default: ;
        endcase
      end
    end
  end

  // Even parity over data+parity, both stop bits must be high.
  assign frame_err  = (^data ^ par_bit) | ~stop1 | ~stop2;
  assign byte_data  = {1'b0, data};
  assign byte_valid = (state == ST_ENTREGA) && !frame_err;
  assign byte_error = (state == ST_ENTREGA) && frame_err;

  // Debug code: the state value when legal, 15 otherwise.
  always_comb begin
    db_estado = 4'hF;
    case (state)
      ST_REPOUSO, ST_INICIO, ST_DADOS, ST_PARIDADE,
      ST_PARADA1, ST_PARADA2, ST_ENTREGA: db_estado = state;
      default: ;
    endcase
  end

endmodule

// File: rtl/sonar_rx.sv
// Sonar frame receiver: parses "AAA,DDD#" frames of BCD digits from the
// serial receiver and publishes angle/distance on each complete frame.
module sonar_rx
  import sonar_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic      clock,
  input  logic      reset,
  sonar_rx_if.master bus
);

  logic [7:0]  byte_data;
  logic        byte_valid, byte_error;
  logic [2:0]  pos;
  logic [23:0] shadow;
  logic [11:0] angulo_q, distancia_q;
  logic        pronto_q, erro_formato_q;

  sonar_rx_serial #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_serial (
    .clock      (clock),
    .reset      (reset),
    .rx         (bus.rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_error (byte_error),
    .db_estado  (bus.db_estado)
  );

  // Frame parser: position counter, digit shadow and published outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos            <= '0;
      shadow         <= '0;
      angulo_q       <= '0;
      distancia_q    <= '0;
      pronto_q       <= 1'b0;
      erro_formato_q <= 1'b0;
    end else begin
      pronto_q       <= 1'b0;
      erro_formato_q <= 1'b0;
      if (byte_error) begin
        pos <= '0;
      end else if (byte_valid) begin
        if (!char_ok(pos, byte_data)) begin
          // The bad character is dropped, not retried as a first digit.
          erro_formato_q <= 1'b1;
          shadow         <= '0;
          pos            <= '0;
        end else if (pos == 3'd7) begin
          angulo_q    <= shadow[23:12];
          distancia_q <= shadow[11:0];
          pronto_q    <= 1'b1;
          pos         <= '0;
        end else begin
          case (pos)
            3'd0: shadow[23:20] <= byte_data[3:0];
            3'd1: shadow[19:16] <= byte_data[3:0];
            3'd2: shadow[15:12] <= byte_data[3:0];
            3'd4: shadow[11:8]  <= byte_data[3:0];
            3'd5: shadow[7:4]   <= byte_data[3:0];
            3'd6: shadow[3:0]   <= byte_data[3:0];
            default: ;
          endcase
          pos <= pos + 1'b1;
        end
      end
    end
  end

  assign bus.angulo       = angulo_q;
  assign bus.distancia    = distancia_q;
  assign bus.pronto       = pronto_q;
  assign bus.erro_formato = erro_formato_q;
  assign bus.erro_serial  = byte_error;

endmodule

// File: tb/tb_sonar_rx.sv
// Directed bench for sonar_rx, run with a short bit period to keep the run small.
module tb_sonar_rx;
  import sonar_rx_pkg::*;

  localparam int CLKS = 32;
  localparam int HALF = CLKS / 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_pronto = 0, n_serr = 0, n_ferr = 0, n_excl = 0;
  int   last_pronto_cyc = 0;

  sonar_rx_if bus ();

  sonar_rx #(.CLKS_PER_BIT(CLKS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Pulse counters sampled on the falling edge.
  always @(negedge clock) begin
    if (bus.pronto) begin
      n_pronto        <= n_pronto + 1;
      last_pronto_cyc <= cyc;
    end
    if (bus.erro_serial)  n_serr <= n_serr + 1;
    if (bus.erro_formato) n_ferr <= n_ferr + 1;
    if (32'(bus.pronto) + 32'(bus.erro_serial) + 32'(bus.erro_formato) > 1) n_excl <= n_excl + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // All drive tasks start and end at posedge+1.
  task automatic drive_bit(input logic b);
    bus.rx = b;
    repeat (CLKS) @(posedge clock);
    #1;
  endtask

  task automatic send_char(input logic [7:0] c, input logic bad_parity, output int start_cyc);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 7; i++) drive_bit(c[i]);
    drive_bit((^c[6:0]) ^ bad_parity);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic send_frame(input string s, input int bad_idx, output int last_start);
    int st;
    last_start = 0;
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i], i == bad_idx, st);
      last_start = st;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.rx = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (bus.angulo !== 12'h000) begin failures++; $display("FAIL reset_angulo: got %h want 000", bus.angulo); end
    checks++; if (bus.distancia !== 12'h000) begin failures++; $display("FAIL reset_distancia: got %h want 000", bus.distancia); end
    checks++; if (bus.pronto !== 1'b0) begin failures++; $display("FAIL reset_pronto: got %b want 0", bus.pronto); end
    checks++; if (bus.erro_serial !== 1'b0) begin failures++; $display("FAIL reset_erro_serial: got %b want 0", bus.erro_serial); end
    checks++; if (bus.erro_formato !== 1'b0) begin failures++; $display("FAIL reset_erro_formato: got %b want 0", bus.erro_formato); end
    checks++; if (bus.db_estado !== 4'd0) begin failures++; $display("FAIL reset_db_estado: got %0d want 0", bus.db_estado); end
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic test_frame_ok;
    int p0 = n_pronto, s0 = n_serr, f0 = n_ferr, ls;
    send_frame("090,035#", -1, ls);
    checks++; if (n_pronto - p0 !== 1) begin failures++; $display("FAIL ok_pronto_count: got %0d want 1", n_pronto - p0); end
    checks++; if ((n_serr - s0) + (n_ferr - f0) !== 0) begin failures++; $display("FAIL ok_error_count: got %0d want 0", (n_serr - s0) + (n_ferr - f0)); end
    checks++; if (bus.angulo !== 12'h090) begin failures++; $display("FAIL ok_angulo: got %h want 090", bus.angulo); end
    checks++; if (bus.distancia !== 12'h035) begin failures++; $display("FAIL ok_distancia: got %h want 035", bus.distancia); end
    // Start edge: 2 sync + 1 edge detect, half bit, 10 bit periods to stop-2 sample, entrega, pronto.
    checks++; if (last_pronto_cyc !== ls + 4 + HALF + 10 * CLKS) begin failures++; $display("FAIL ok_latency: got %0d want %0d", last_pronto_cyc, ls + 4 + HALF + 10 * CLKS); end
  endtask

  task automatic test_parity_error;
    int p0 = n_pronto, s0 = n_serr, f0 = n_ferr, ls;
    // Bad parity on '1' (index 4); the trailing "20#" then fails at '#' in position 2.
    send_frame("045,120#", 4, ls);
    checks++; if (n_serr - s0 !== 1) begin failures++; $display("FAIL par_serr_count: got %0d want 1", n_serr - s0); end
    checks++; if (n_pronto - p0 !== 0) begin failures++; $display("FAIL par_pronto_count: got %0d want 0", n_pronto - p0); end
    checks++; if (n_ferr - f0 !== 1) begin failures++; $display("FAIL par_ferr_count: got %0d want 1", n_ferr - f0); end
    checks++; if (bus.angulo !== 12'h090) begin failures++; $display("FAIL par_angulo_hold: got %h want 090", bus.angulo); end
    p0 = n_pronto; s0 = n_serr; f0 = n_ferr;
    send_frame("045,120#", -1, ls);
    checks++; if (n_pronto - p0 !== 1) begin failures++; $display("FAIL par_retry_pronto: got %0d want 1", n_pronto - p0); end
    checks++; if ((n_serr - s0) + (n_ferr - f0) !== 0) begin failures++; $display("FAIL par_retry_errors: got %0d want 0", (n_serr - s0) + (n_ferr - f0)); end
    checks++; if (bus.angulo !== 12'h045) begin failures++; $display("FAIL par_retry_angulo: got %h want 045", bus.angulo); end
    checks++; if (bus.distancia !== 12'h120) begin failures++; $display("FAIL par_retry_distancia: got %h want 120", bus.distancia); end
  endtask

  task automatic test_format_error;
    int p0 = n_pronto, s0 = n_serr, f0 = n_ferr, ls;
    send_frame("09A", -1, ls);
    checks++; if (n_ferr - f0 !== 1) begin failures++; $display("FAIL fmt_at_A: got %0d want 1", n_ferr - f0); end
    // After the reset to position 0, ',' and the '#' in position 3 are also misplaced.
    send_frame(",035#", -1, ls);
    checks++; if (n_ferr - f0 !== 3) begin failures++; $display("FAIL fmt_total: got %0d want 3", n_ferr - f0); end
    checks++; if (n_pronto - p0 !== 0) begin failures++; $display("FAIL fmt_pronto: got %0d want 0", n_pronto - p0); end
    checks++; if (n_serr - s0 !== 0) begin failures++; $display("FAIL fmt_serr: got %0d want 0", n_serr - s0); end
    checks++; if (bus.angulo !== 12'h045) begin failures++; $display("FAIL fmt_angulo_hold: got %h want 045", bus.angulo); end
    checks++; if (bus.distancia !== 12'h120) begin failures++; $display("FAIL fmt_distancia_hold: got %h want 120", bus.distancia); end
  endtask

  task automatic test_false_start;
    int p0 = n_pronto, s0 = n_serr, f0 = n_ferr;
    logic [3:0] max_st = 4'd0;
    // Low glitch shorter than half a bit.
    bus.rx = 1'b0;
    for (int i = 0; i < 10 + 3 * CLKS; i++) begin
      @(negedge clock);
      if (bus.db_estado > max_st) max_st = bus.db_estado;
      if (i == 9) bus.rx = 1'b1;
    end
    @(posedge clock);
    #1;
    checks++; if (max_st !== 4'd1) begin failures++; $display("FAIL glitch_max_state: got %0d want 1", max_st); end
    checks++; if (bus.db_estado !== 4'd0) begin failures++; $display("FAIL glitch_db_estado: got %0d want 0", bus.db_estado); end
    checks++; if ((n_pronto - p0) + (n_serr - s0) + (n_ferr - f0) !== 0) begin failures++; $display("FAIL glitch_pulses: got %0d want 0", (n_pronto - p0) + (n_serr - s0) + (n_ferr - f0)); end
  endtask

  task automatic test_back_to_back;
    int p0 = n_pronto, s0 = n_serr, f0 = n_ferr, ls;
    send_frame("000,001#", -1, ls);
    checks++; if (bus.distancia !== 12'h001) begin failures++; $display("FAIL b2b_first_distancia: got %h want 001", bus.distancia); end
    send_frame("180,400#", -1, ls);
    checks++; if (n_pronto - p0 !== 2) begin failures++; $display("FAIL b2b_pronto_count: got %0d want 2", n_pronto - p0); end
    checks++; if ((n_serr - s0) + (n_ferr - f0) !== 0) begin failures++; $display("FAIL b2b_errors: got %0d want 0", (n_serr - s0) + (n_ferr - f0)); end
    checks++; if (bus.angulo !== 12'h180) begin failures++; $display("FAIL b2b_angulo: got %h want 180", bus.angulo); end
    checks++; if (bus.distancia !== 12'h400) begin failures++; $display("FAIL b2b_distancia: got %h want 400", bus.distancia); end
  endtask

  task automatic test_reset_mid_frame;
    int p0 = n_pronto, s0 = n_serr, f0 = n_ferr, ls;
    logic [7:0] d1 = "3";
    send_frame("090,0", -1, ls);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d1[i]);
    reset = 1'b1;
    bus.rx = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    checks++; if (bus.angulo !== 12'h000) begin failures++; $display("FAIL midrst_angulo_cleared: got %h want 000", bus.angulo); end
    repeat (2 * CLKS) @(posedge clock);
    #1;
    send_frame("010,020#", -1, ls);
    checks++; if (n_pronto - p0 !== 1) begin failures++; $display("FAIL midrst_pronto_count: got %0d want 1", n_pronto - p0); end
    checks++; if ((n_serr - s0) + (n_ferr - f0) !== 0) begin failures++; $display("FAIL midrst_errors: got %0d want 0", (n_serr - s0) + (n_ferr - f0)); end
    checks++; if (bus.angulo !== 12'h010) begin failures++; $display("FAIL midrst_angulo: got %h want 010", bus.angulo); end
    checks++; if (bus.distancia !== 12'h020) begin failures++; $display("FAIL midrst_distancia: got %h want 020", bus.distancia); end
  endtask

  task automatic test_exclusive;
    checks++; if (n_excl !== 0) begin failures++; $display("FAIL pulse_exclusive: got %0d overlapping cycles want 0", n_excl); end
  endtask

  initial begin
    bus.rx = 1'b1;
    @(posedge clock);
    #1;
    test_reset();
    test_frame_ok();
    test_parity_error();
    test_format_error();
    test_false_start();
    test_back_to_back();
    test_reset_mid_frame();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sonar_rx.md
SONAR_RX -- requirements
Module: sonar_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, sets clock cycles per serial bit (50 MHz / 115200 baud).
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; returns the block to its reset state.
REQ-004 rx  input  1  serial line, idle high, asynchronous to clock.
REQ-005 angulo  output  12  last accepted angle, 3 BCD digits, hundreds in [11:8].
REQ-006 distancia  output  12  last accepted distance, 3 BCD digits, hundreds in [11:8].
REQ-007 pronto  output  1  one-cycle pulse when a complete valid frame is accepted.
REQ-008 erro_serial  output  1  one-cycle pulse on a parity or stop-bit error.
REQ-009 erro_formato  output  1  one-cycle pulse on an illegal character in a frame.
REQ-010 db_estado  output  4  debug code of the bit-level receiver state.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Character format SHALL be 7E2: start bit (0), 7 data bits LSB first, even parity, 2 stop bits (1).
REQ-013 Receiver states SHALL be: repouso 0, inicio 1, dados 2, paridade 3, parada1 4, parada2 5, entrega 6; db_estado SHALL show these codes, with 15 for any other state.
REQ-014 Receiver transitions: repouso -> inicio on a synchronized falling edge; inicio waits CLKS_PER_BIT/2 cycles, then goes to dados if rx=0, otherwise returns to repouso (false start, no error pulse).
REQ-015 dados, paridade, parada1 and parada2 SHALL each sample rx once, CLKS_PER_BIT cycles after the previous sample; dados SHALL take 7 samples.
REQ-016 entrega SHALL last exactly one cycle, then return to repouso.
REQ-017 Bad even parity, or either stop bit = 0, SHALL pulse erro_serial in the entrega cycle, discard the byte and reset the frame parser to position 0.
REQ-018 A good byte SHALL be handed to the frame parser in the entrega cycle.
REQ-019 Frame SHALL be 8 characters in order: A2 A1 A0 ',' D2 D1 D0 '#'; digits are ASCII '0'-'9' (0x30-0x39).
REQ-020 Frame parser: a position counter 0-7 and a 24-bit shadow register SHALL hold digit low nibbles.
REQ-021 Wrong character at any position SHALL pulse erro_formato on the cycle after entrega, clear the shadow register and set position to 0; the offending character SHALL NOT be re-evaluated as a first digit.
REQ-022 Accepted '#' at position 7 SHALL, on the cycle after entrega: copy the shadow register to angulo/distancia, pulse pronto, and set position to 0.
REQ-023 angulo and distancia SHALL change only together with pronto and SHALL hold their value otherwise.
REQ-024 Latency: pronto SHALL rise 2 cycles after the second stop-bit sample of '#'.
REQ-025 Frames SHALL be accepted back-to-back with zero idle time after the second stop bit.
REQ-026 pronto, erro_serial and erro_formato SHALL be mutually exclusive in any cycle.

Reset
REQ-027 Reset SHALL give: receiver repouso, parser position 0, shadow 0, angulo=0, distancia=0, pronto=0, erro_serial=0, erro_formato=0, db_estado=0, synchronizer flops=1.
REQ-028 Reset mid-character or mid-frame SHALL abandon the partial data without emitting any pulse; reception SHALL restart at the next falling edge after reset release.

Structure
REQ-029 A shared package SHALL hold the receiver state codes and the ASCII constants ',', '#', '0', '9'.
REQ-030 The bit-level receiver SHALL be a sub-module named sonar_rx_serial (outputs byte, byte_valid, byte_error, db_estado); frame parsing SHALL stay in sonar_rx.

Verification (CLKS_PER_BIT=434 unless stated)
REQ-031 Send "090,035#" -> one pronto pulse, angulo=0x090, distancia=0x035, no error pulses.
REQ-032 Send "045,120#" with wrong parity on '1' -> erro_serial once, no pronto; then send "045,120#" -> pronto, angulo=0x045, distancia=0x120.
REQ-033 Send "09A,035#" -> erro_formato once at 'A', no pronto; outputs keep their previous values.
REQ-034 Drive rx low for 100 cycles, then high -> no state beyond inicio, no pulses, db_estado returns to 0.
REQ-035 Send two frames back-to-back, "000,001#" then "180,400#" -> two pronto pulses, final angulo=0x180, distancia=0x400.
REQ-036 Assert reset during D1 of "090,035#", release it, then send "010,020#" -> exactly one pronto, angulo=0x010, distancia=0x020.
